// File: rtl/core_fifo_sync_ctrl.sv
// core_fifo_sync_ctrl: synchronous FIFO pointer/flag controller driving an external 1-cycle-latency RAM
module core_fifo_sync_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_VAL  = 12,
  parameter int AEMPTY_VAL = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   wcount
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_WIDTH;
  localparam logic [CW-1:0] AF_T = CW'(AFULL_VAL);
  localparam logic [CW-1:0] AE_T = CW'(AEMPTY_VAL);
  logic [CW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, afull_q, afull_d, aempty_q, aempty_d;
  logic ovf_q, ovf_d, unf_q, unf_d, rvalid_q, rvalid_d;
  logic wr_acc, rd_acc;
  always_comb begin
    wr_acc   = we & ~full_q;
    rd_acc   = re & ~empty_q;
    wptr_d   = wptr_q + CW'(wr_acc);
    rptr_d   = rptr_q + CW'(rd_acc);
    // extra pointer bit makes the modular difference the exact occupancy 0..D
    count_d  = wptr_d - rptr_d;
    full_d   = count_d == DEPTH;
    empty_d  = count_d == '0;
    afull_d  = count_d >= AF_T;
    aempty_d = count_d <= AE_T;
    ovf_d    = we & full_q;
    unf_d    = re & empty_q;
    rvalid_d = rd_acc;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign mem_we    = we & ~full_q & ~reset;
  assign waddr     = wptr_q[ADDR_WIDTH-1:0];
  assign raddr     = rptr_q[ADDR_WIDTH-1:0];
  assign wcount    = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign afull     = afull_q;
  assign aempty    = aempty_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign rvalid    = rvalid_q;
endmodule
